tune_sequencer: RTL and testbench

//  Autonomous melody player driving the buzzer tone generator with active-low one-hot key codes,
//  the same code set as the front-panel keys.
//  It walks an internal song ROM of {key_code, beats} entries and times each note in beat ticks.
//  It inserts a short silent articulation gap at the end of every note.
//  Its key output is muxed with the physical key bus upstream of the tone generator.

---
 rtl/tune_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_tune_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tune_sequencer.sv
// ---------------------------------------------------------------------------
// tune_sequencer
//   Autonomous melody player. Walks a fixed song ROM of {key_code, beats}
//   entries and drives the buzzer tone generator with active-low one-hot key
//   codes (same code set as the front-panel keys; 8'hff = silent). Each note
//   lasts exactly beats*TICK_DIV cycles, of which the last GAP_CYC cycles are
//   a silent articulation gap. beats=0 marks end of song; code=8'hff is a
//   timed rest.
//
// Parameters
//   TICK_DIV  clk cycles per beat (must be > GAP_CYC)
//   GAP_CYC   silent cycles at the end of every note (must be >= 1)
//   DEPTH     song ROM entries
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active-high
//   start     1-cycle pulse: play from entry 0 (ignored while busy)
//   stop      abort playback, return to idle (beats start)
//   loop_en   wrap to entry 0 at end of song instead of finishing
//   pause     (TUNE_PAUSE_EN only) freeze current note, key forced silent
//   key       active-low note code, 8'hff = silent
//   busy      high while a note or its gap is in progress
//   done      1-cycle pulse when a non-looped song completes
//   note_idx  ROM index currently sounding
//
// Build option
//   TUNE_PAUSE_EN  adds the pause input. Undefined: no pause port.
//
// All outputs are registered; the FSM computes next-cycle output values
// combinationally and a single register stage holds state and outputs.
// ---------------------------------------------------------------------------
module tune_sequencer #(
  parameter int TICK_DIV = 6_250_000,
  parameter int GAP_CYC  = 500_000,
  parameter int DEPTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
`ifdef TUNE_PAUSE_EN
  input  logic                     pause,
`endif
  output logic [7:0]               key,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] note_idx
);

  localparam int AW = $clog2(DEPTH);
  // Wide enough for the longest note (15 beats); the counter never wraps.
  localparam int CW = $clog2(15*TICK_DIV+1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Song ROM. Unlisted entries read as {ff, 0}, i.e. end-of-song.
  // -------------------------------------------------------------------------
  function automatic logic [7:0] rom_code(input logic [AW-1:0] a);
    logic [7:0] c;
    c = 8'hff;
    case (int'(a))
      0:       c = 8'hfe;
      1:       c = 8'hfb;
      2:       c = 8'hef;
      3:       c = 8'h7f;
      4:       c = 8'hff;
      default: c = 8'hff;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] rom_beats(input logic [AW-1:0] a);
    logic [3:0] b;
    b = 4'd0;
    case (int'(a))
      0:       b = 4'd2;
      1:       b = 4'd1;
      2:       b = 4'd1;
      3:       b = 4'd4;
      4:       b = 4'd1;
      default: b = 4'd0;
    endcase
    return b;
  endfunction

  // Counter load for the sounding part of a note. The counter counts down to
  // zero, so a phase of N cycles loads N-1. Caller guarantees beats != 0.
  function automatic logic [CW-1:0] play_len(input logic [3:0] beats);
    return CW'(beats) * CW'(TICK_DIV) - CW'(GAP_CYC) - CW'(1);
  endfunction

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [AW-1:0]   idx_q,   idx_d;
  logic [7:0]      key_q,   key_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;

  // Freeze request; stop still wins because it is decoded first.
  logic hold;
`ifdef TUNE_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  logic [AW-1:0] nxt;
  logic          last;
  logic          go_play;
  logic [AW-1:0] tgt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      key_q   <= 8'hff;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    key_d   = key_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    go_play = 1'b0;
    tgt     = '0;

    // End of song: last ROM slot, or the following entry is the end marker.
    nxt  = idx_q + AW'(1);
    last = (idx_q == AW'(DEPTH-1)) || (rom_beats(nxt) == 4'd0);

    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      key_d   = 8'hff;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          key_d  = 8'hff;
          busy_d = 1'b0;
          if (start) begin
            idx_d = '0;
            // An empty song completes immediately without leaving IDLE.
            if (rom_beats(AW'(0)) == 4'd0) done_d  = 1'b1;
            else                           go_play = 1'b1;
          end
        end

        PLAY: begin
          if (hold) begin
            key_d = 8'hff;
          end else if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = CW'(GAP_CYC-1);
            key_d   = 8'hff;
          end else begin
            cnt_d = cnt_q - CW'(1);
            // Re-asserted every cycle so a note resumes after a pause.
            key_d = rom_code(idx_q);
          end
        end

        GAP: begin
          if (!hold) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CW'(1);
            end else if (!last) begin
              go_play = 1'b1;
              tgt     = nxt;
            end else if (loop_en) begin
              // Wrap straight into entry 0, no dead cycle.
              go_play = 1'b1;
              tgt     = '0;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
              idx_d   = '0;
              key_d   = 8'hff;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          key_d   = 8'hff;
          busy_d  = 1'b0;
        end
      endcase

      if (go_play) begin
        state_d = PLAY;
        idx_d   = tgt;
        cnt_d   = play_len(rom_beats(tgt));
        key_d   = rom_code(tgt);
        busy_d  = 1'b1;
      end
    end
  end

  assign key      = key_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule

// File: tb/tb_tune_sequencer.sv
// Randomized/directed bench for tune_sequencer. A reference model tracks the
// elapsed time inside the song and derives the expected outputs from the
// note table; expectations go into a queue popped by an independent monitor.
module tb_tune_sequencer;
  localparam int TICK_DIV = 10;
  localparam int GAP_CYC  = 2;
  localparam int DEPTH    = 32;
  localparam int AW       = $clog2(DEPTH);
  localparam int NNOTES   = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [7:0]    key;
  logic          busy;
  logic          done;
  logic [AW-1:0] note_idx;

  always #5 clk = ~clk;

  tune_sequencer #(
    .TICK_DIV(TICK_DIV),
    .GAP_CYC (GAP_CYC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .loop_en (loop_en),
    .key     (key),
    .busy    (busy),
    .done    (done),
    .note_idx(note_idx)
  );

  typedef struct packed {
    logic [7:0]    key;
    logic          busy;
    logic          done;
    logic [AW-1:0] idx;
    logic          chk_idx;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] song_code [NNOTES] = '{8'hfe, 8'hfb, 8'hef, 8'h7f, 8'hff};
  int         song_beats[NNOTES] = '{2, 1, 1, 4, 1};

  function automatic int song_len();
    int s = 0;
    for (int i = 0; i < NNOTES; i++) s += song_beats[i] * TICK_DIV;
    return s;
  endfunction

  // Expected key/index at elapsed cycle e within the song.
  function automatic exp_t at_time(input int e);
    exp_t x;
    int   base = 0;
    x = '{key: 8'hff, busy: 1'b1, done: 1'b0, idx: '0, chk_idx: 1'b1};
    for (int i = 0; i < NNOTES; i++) begin
      int len = song_beats[i] * TICK_DIV;
      if (e >= base && e < base + len) begin
        x.idx = AW'(i);
        x.key = (e - base < len - GAP_CYC) ? song_code[i] : 8'hff;
      end
      base += len;
    end
    return x;
  endfunction

  // Reference model: one expectation per clock edge.
  initial begin
    bit   m_play = 0;
    int   m_e    = 0;
    bit   m_done;
    exp_t x;
    forever begin
      @(posedge clk);
      m_done = 0;
      if (rst) begin
        m_play = 0;
        m_e    = 0;
      end else if (stop) begin
        m_play = 0;
      end else if (m_play) begin
        m_e++;
        if (m_e == song_len()) begin
          if (loop_en) m_e = 0;
          else begin
            m_play = 0;
            m_done = 1;
          end
        end
      end else if (start) begin
        m_play = 1;
        m_e    = 0;
      end
      if (m_play) x = at_time(m_e);
      else x = '{key: 8'hff, busy: 1'b0, done: m_done, idx: '0, chk_idx: rst};
      sb_q.push_back(x);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Monitor: sample away from the active edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        x = sb_q.pop_front();
        chk("key",  int'(key),  int'(x.key));
        chk("busy", int'(busy), int'(x.busy));
        chk("done", int'(done), int'(x.done));
        if (x.chk_idx) chk("note_idx", int'(note_idx), int'(x.idx));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    // reset held, then idle with no start
    repeat (3) step();
    rst = 1'b0;
    repeat (6) step();

    // single pass, no loop
    loop_en = 1'b0;
    start = 1'b1; step();
    repeat (99) step();

    // looped play with a start re-pulse at cycle 10
    loop_en = 1'b1;
    start = 1'b1; step();
    repeat (9) step();
    start = 1'b1; step();
    repeat (110) step();
    loop_en = 1'b0;
    repeat (100) step();

    // stop at cycle 25, restart at cycle 30
    start = 1'b1; step();
    repeat (24) step();
    stop = 1'b1; step();
    repeat (4) step();
    start = 1'b1; step();
    repeat (20) step();
    stop = 1'b1; step();

    // start and stop together from IDLE
    start = 1'b1; stop = 1'b1; step();
    repeat (5) step();

    // reset mid-note
    start = 1'b1; step();
    repeat (30) step();
    rst = 1'b1; step();
    rst = 1'b0;
    repeat (5) step();

    // random traffic
    repeat (4000) begin
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) loop_en = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 1499) == 0);
      step();
    end
    rst = 1'b0;
    repeat (3) step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
